// File: rtl/pit_multi_timer.sv
// N-channel programmable interval timer, modes 0/2/3 with count latch.
// Optional PIT_STATUS_EN macro adds the status register and snapshot.
module pit_multi_timer #(
  parameter int CHANNELS = 3,
  parameter int WIDTH = 16,
  localparam int AW = $clog2(CHANNELS) + 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic                rd_en,
  input  logic [AW-1:0]       addr,
  input  logic [WIDTH-1:0]    wdata,
  output logic [WIDTH-1:0]    rdata,
  output logic                rd_valid,
  input  logic [CHANNELS-1:0] tick,
  input  logic [CHANNELS-1:0] gate,
  output logic [CHANNELS-1:0] out
);

  logic [AW-1:0]    ch_sel;
  logic [1:0]       rsel;
  logic [WIDTH-1:0] rd_word [CHANNELS];
  logic [WIDTH-1:0] rd_mux;

  assign ch_sel = addr >> 2;
  assign rsel = addr[1:0];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] count, reload, latch;
    logic [1:0]       mode;
    logic             en, armed, latched, need, out_q;
    logic             wr_hit, rd_hit, qtick;
    logic [WIDTH-1:0] w_reload, w_latch, n_count;
    logic [1:0]       w_mode;
    logic             w_en, w_armed, w_latched, w_need, w_out;
    logic             n_armed, n_latched, n_need, n_out;
    logic [WIDTH-1:0] r_eff, lo_len, hi_len, rword, stat_word;
    logic [WIDTH:0]   hi_sum;

    assign wr_hit = wr_en && (ch_sel == AW'(i));
    assign rd_hit = rd_en && (ch_sel == AW'(i));
    assign qtick = tick[i] & en & armed & gate[i] & ~wr_hit;
    assign out[i] = out_q;
    assign rd_word[i] = rword;

    // Modes 2/3 cannot run with a period below 2.
    assign r_eff = (mode[1] && reload < WIDTH'(2)) ? WIDTH'(2) : reload;
    assign hi_sum = {1'b0, r_eff} + (WIDTH+1)'(1);
    assign hi_len = hi_sum[WIDTH:1];
    assign lo_len = r_eff >> 1;

    always_comb begin
      w_reload = reload;
      w_latch = latch;
      w_mode = mode;
      w_en = en;
      w_armed = armed;
      w_latched = latched;
      w_need = need;
      w_out = out_q;
      if (wr_hit) begin
        unique case (1'b1)
          rsel == 2'd0: begin
            w_reload = wdata;
            w_armed = 1'b1;
            w_need = 1'b1;
            if (!mode[1]) w_out = 1'b0;
          end
          rsel == 2'd1: begin
            w_en = wdata[2];
            w_mode = wdata[1:0];
            w_armed = 1'b0;
            w_latched = 1'b0;
            w_need = 1'b1;
            w_out = wdata[1];
          end
          rsel == 2'd3: begin
            if (!latched) begin
              w_latch = count;
              w_latched = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end

    always_comb begin
      n_count = count;
      n_out = w_out;
      n_armed = w_armed;
      n_need = w_need;
      n_latched = w_latched & ~(rd_hit && rsel == 2'd0);
      if (!wr_hit) begin
        if (mode[1] && en && !gate[i]) begin
          n_out = 1'b1;
          n_need = 1'b1;
        end else if (qtick) begin
          if (need) begin
            n_need = 1'b0;
            n_count = (mode == 2'b11) ? hi_len : r_eff;
            if (mode[1]) n_out = 1'b1;
          end else if (!mode[1]) begin
            n_count = count - WIDTH'(1);
            if (count == WIDTH'(1)) begin
              n_out = 1'b1;
              n_armed = 1'b0;
            end
          end else if (count == WIDTH'(1)) begin
            if (mode == 2'b10) begin
              n_count = r_eff;
              n_out = 1'b0;
            end else begin
              n_count = out_q ? lo_len : hi_len;
              n_out = ~out_q;
            end
          end else begin
            n_count = count - WIDTH'(1);
            if (mode == 2'b10) n_out = 1'b1;
          end
        end
      end
    end

`ifdef PIT_STATUS_EN
    logic [5:0] snap, snap_w, stat_w;
    logic       snap_v, snap_vw;

    assign stat_w = {w_latched, w_armed, w_out, w_en, w_mode};
    assign snap_w = (wr_hit && rsel == 2'd1 && wdata[3]) ? stat_w : snap;
    assign snap_vw = (wr_hit && rsel == 2'd1) ? wdata[3] : snap_v;
    assign stat_word = WIDTH'(snap_vw ? snap_w : stat_w);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        snap <= '0;
        snap_v <= 1'b0;
      end else begin
        snap <= snap_w;
        snap_v <= snap_vw & ~(rd_hit && rsel == 2'd2);
      end
    end
`else
    assign stat_word = '0;
`endif

    always_comb begin
      rword = '0;
      case (rsel)
        2'd0: rword = w_latched ? w_latch : count;
        2'd1: rword = WIDTH'({w_en, w_mode});
        2'd2: rword = stat_word;
        default: rword = '0;
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        count <= '0;
        reload <= '0;
        latch <= '0;
        mode <= '0;
        en <= 1'b0;
        armed <= 1'b0;
        latched <= 1'b0;
        need <= 1'b0;
        out_q <= 1'b0;
      end else begin
        count <= n_count;
        reload <= w_reload;
        latch <= w_latch;
        mode <= w_mode;
        en <= w_en;
        armed <= n_armed;
        latched <= n_latched;
        need <= n_need;
        out_q <= n_out;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < CHANNELS; k++)
      if (ch_sel == AW'(k)) rd_mux = rd_word[k];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_pit_multi_timer.sv
// Directed bench for pit_multi_timer (3 channels, 16-bit).
// Status expectations follow the PIT_STATUS_EN build option.
module tb_pit_multi_timer;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [3:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        rd_valid;
  logic [2:0]  tick;
  logic [2:0]  gate;
  logic [2:0]  out;

  int checks = 0;
  int fails = 0;

  pit_multi_timer dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .rd_en(rd_en),
    .addr(addr), .wdata(wdata),
    .rdata(rdata), .rd_valid(rd_valid),
    .tick(tick), .gate(gate), .out(out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input int ch, input int r,
                    input logic [15:0] d);
    @(negedge clk);
    wr_en = 1'b1;
    addr = 4'(ch * 4 + r);
    wdata = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd(input int ch, input int r,
                    output logic [15:0] d);
    @(negedge clk);
    rd_en = 1'b1;
    addr = 4'(ch * 4 + r);
    @(negedge clk);
    rd_en = 1'b0;
    d = rdata;
  endtask

  task automatic pulse(input int ch, input int n);
    @(negedge clk);
    tick[ch] = 1'b1;
    repeat (n) @(negedge clk);
    tick[ch] = 1'b0;
  endtask

  logic [15:0] d;
  logic [11:0] pat;
  logic [15:0] exp_stat;

  initial begin
    rst = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    addr = '0;
    wdata = '0;
    tick = '0;
    gate = 3'b111;
    repeat (2) @(negedge clk);
    check("rst_out", out, 3'b000);
    check("rst_rdata", rdata, 0);
    check("rst_rdv", rd_valid, 0);
    rst = 1'b0;

    // mode 0, reload 5
    wr(0, 1, 16'h0004);
    wr(0, 0, 16'd5);
    check("m0_out_after_wr", out[0], 0);
    @(negedge clk);
    tick[0] = 1'b1;
    repeat (5) @(negedge clk);
    check("m0_out_5", out[0], 0);
    @(negedge clk);
    check("m0_out_6", out[0], 1);
    repeat (2) @(negedge clk);
    tick[0] = 1'b0;
    rd(0, 0, d);
    check("m0_hold", d, 0);
    check("m0_rdv", rd_valid, 1);

    // mode 2, reload 4
    wr(1, 1, 16'h0006);
    wr(1, 0, 16'd4);
    @(negedge clk);
    tick[1] = 1'b1;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      pat[n] = out[1];
    end
    check("m2_pattern", pat, 12'hEEF);
    gate[1] = 1'b0;
    repeat (3) @(negedge clk);
    check("m2_gate_out", out[1], 1);
    tick[1] = 1'b0;
    rd(1, 0, d);
    check("m2_gate_hold", d, 1);
    gate[1] = 1'b1;
    pulse(1, 1);
    rd(1, 0, d);
    check("m2_reload", d, 4);
    check("m2_out_after", out[1], 1);

    // mode 3, reload 5 then 1
    wr(2, 1, 16'h0007);
    wr(2, 0, 16'd5);
    @(negedge clk);
    tick[2] = 1'b1;
    pat = '0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      pat[n] = out[2];
    end
    tick[2] = 1'b0;
    check("m3_r5", pat, 12'h0E7);
    wr(2, 0, 16'd1);
    @(negedge clk);
    tick[2] = 1'b1;
    pat = '0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      pat[n] = out[2];
    end
    tick[2] = 1'b0;
    check("m3_r1", pat, 12'h015);

    // latch
    wr(0, 1, 16'h0004);
    wr(0, 0, 16'h1234);
    check("m0_rearm_out", out[0], 0);
    pulse(0, 1);
    wr(0, 3, 16'h0);
    pulse(0, 3);
    rd(0, 0, d);
    check("latch_rd", d, 16'h1234);
    check("latch_rdv", rd_valid, 1);
    @(negedge clk);
    check("rdv_drop", rd_valid, 0);
    check("rdata_hold", rdata, 16'h1234);
    rd(0, 0, d);
    check("live_rd", d, 16'h1231);
    wr(0, 3, 16'h0);
    pulse(0, 1);
    wr(0, 3, 16'h0);
    rd(0, 0, d);
    check("latch_ignore", d, 16'h1231);
    rd(0, 0, d);
    check("live_rd2", d, 16'h1230);

    // write collides with tick
    @(negedge clk);
    tick[0] = 1'b1;
    wr_en = 1'b1;
    addr = 4'h0;
    wdata = 16'h0010;
    @(negedge clk);
    tick[0] = 1'b0;
    wr_en = 1'b0;
    rd(0, 0, d);
    check("wr_wins", d, 16'h1230);
    pulse(0, 1);
    rd(0, 0, d);
    check("load_after", d, 16'h0010);

    // read with concurrent tick sees pre-tick count
    @(negedge clk);
    tick[0] = 1'b1;
    rd_en = 1'b1;
    addr = 4'h0;
    @(negedge clk);
    tick[0] = 1'b0;
    rd_en = 1'b0;
    check("pre_tick_rd", rdata, 16'h0010);
    rd(0, 0, d);
    check("post_tick_rd", d, 16'h000F);

    // status and out-of-range channel
    wr(1, 1, 16'h0006);
    wr(1, 0, 16'd4);
`ifdef PIT_STATUS_EN
    exp_stat = 16'h001E;
`else
    exp_stat = 16'h0000;
`endif
    rd(1, 2, d);
    check("status", d, exp_stat);
    rd(1, 1, d);
    check("ctrl_rd", d, 16'h0006);
    rd(3, 0, d);
    check("oor_rdata", d, 0);
    check("oor_rdv", rd_valid, 1);

    // async reset mid-count
    rd(1, 1, d);
    @(negedge clk);
    tick[0] = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("arst_out", out, 3'b000);
    check("arst_rdata", rdata, 0);
    @(negedge clk);
    tick[0] = 1'b0;
    rst = 1'b0;
    rd(0, 0, d);
    check("arst_count", d, 0);
    rd(1, 1, d);
    check("arst_ctrl", d, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
